// File: rtl/pll_lock_supervisor_if.sv
// PLL reset/lock and system-reset signal bundle between the supervisor (master)
// and the PLL/system side (slave).
interface pll_sup_if #(
  parameter int RELOCK_W = 8
) ();
  // Level signals only, no valid/ready: every signal is sampled on each refclk
  // edge. pll_locked is asynchronous; the rest are registered by the supervisor.
  logic                pll_locked;
  logic                pll_rst;
  logic                sys_rst_n;
  logic                lock_lost;
  logic                fault;
  logic [RELOCK_W-1:0] relock_count;
  logic [2:0]          state_dbg;

  modport master (
    input  pll_locked,
    output pll_rst, sys_rst_n, lock_lost, fault, relock_count, state_dbg
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst_n, lock_lost, fault, relock_count, state_dbg
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification and loss-of-lock recovery on refclk.
// Optional macro PLL_SUP_LOSS_FILTER_EN: require 4 consecutive low samples in RUN.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int RELOCK_W            = 8
) (
  input  logic     refclk,
  input  logic     rst_n,
  pll_sup_if.master bus
);

  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + LOCK_STABLE_CYCLES + PLL_RST_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic [RW-1:0]       retry_cnt;
  logic [RW-1:0]       retry_next;
  logic                sync_q;
  logic                locked_s;
  logic                loss_event;
  logic                pll_rst_q;
  logic                sys_rst_n_q;
  logic                lock_lost_q;
  logic                fault_q;
  logic [RELOCK_W-1:0] relock_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= bus.pll_locked;
      locked_s <= sync_q;
    end
  end

`ifdef PLL_SUP_LOSS_FILTER_EN
  logic [1:0] low_cnt;

  // A lock loss needs four consecutive low samples while running.
  assign loss_event = !locked_s && (low_cnt == 2'd3);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt <= 2'd0;
    end else if (state == ST_RUN && !locked_s && !loss_event) begin
      low_cnt <= low_cnt + 2'd1;
    end else begin
      low_cnt <= 2'd0;
    end
  end
`else
  assign loss_event = !locked_s;
`endif

  assign retry_next = retry_cnt + 1'b1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLL_RESET;
      timer       <= '0;
      retry_cnt   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
      relock_q    <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      case (state)
        ST_PLL_RESET: begin
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          if (timer == RST_LAST) begin
            state     <= ST_WAIT_LOCK;
            timer     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so it beats a coincident timeout.
          if (locked_s) begin
            state <= ST_STABLE;
            timer <= TW'(1);
          end else if (timer == TO_LAST) begin
            timer     <= '0;
            pll_rst_q <= 1'b1;
            retry_cnt <= retry_next;
            if (retry_next == RETRY_MAX) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state <= ST_PLL_RESET;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STABLE: begin
          // The entry sample already counted as the first stable cycle.
          if (!locked_s) begin
            state <= ST_WAIT_LOCK;
            timer <= '0;
          end else if (timer >= STB_LAST) begin
            state       <= ST_RUN;
            timer       <= '0;
            retry_cnt   <= '0;
            sys_rst_n_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RUN: begin
          retry_cnt <= '0;
          if (loss_event) begin
            state       <= ST_PLL_RESET;
            timer       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_lost_q <= 1'b1;
            if (relock_q != {RELOCK_W{1'b1}}) begin
              relock_q <= relock_q + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          fault_q     <= 1'b1;
        end
        default: begin
          state       <= ST_PLL_RESET;
          timer       <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.fault        = fault_q;
  assign bus.relock_count = relock_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle expected output vectors are
// queued by the stimulus and compared by a negedge monitor.
module tb_pll_lock_supervisor;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n;

  pll_sup_if #(.RELOCK_W(2)) bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .RELOCK_W            (2)
  ) dut (
    .refclk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int             c0 = 0;
  int             checks = 0;
  int             errors = 0;
  bit             done = 1'b0;
  bit             done_seen = 1'b0;
  string          scen = "init";
  logic [W-1:0]   exp_q[$];
  int             exp_cyc_q[$];

  // {pll_rst, sys_rst_n, lock_lost, fault, relock_count, state_dbg}
  function automatic logic [W-1:0] v(input logic pr, input logic sr, input logic ll,
                                     input logic f, input logic [1:0] rc,
                                     input logic [2:0] st);
    return {pr, sr, ll, f, rc, st};
  endfunction

  localparam logic [W-1:0] R0   = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
  localparam logic [W-1:0] WL0  = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
  localparam logic [W-1:0] ST0  = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2};
  localparam logic [W-1:0] RUN0 = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3};
  localparam logic [W-1:0] FLT0 = {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4};

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] got;
    logic [W-1:0] e;
    int           tc;
    got = {bus.pll_rst, bus.sys_rst_n, bus.lock_lost, bus.fault,
           bus.relock_count, bus.state_dbg};
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      tc = exp_cyc_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (tc != cyc || got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d got %b want %b", scen, tc - c0, got, e);
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_span(input int lo, input int hi, input logic [W-1:0] e);
    for (int k = lo; k <= hi; k++) begin
      exp_cyc_q.push_back(c0 + k);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < c0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a posedge; reset values must show before the next edge.
  task automatic reset_now();
    scen = "reset";
    c0 = cyc;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    exp_span(0, 2, R0);
    wait_to(3);
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic bring_up_clean();
    scen = "bring_up";
    exp_span(0, 3, R0);
    exp_span(4, 12, WL0);
    exp_span(13, 19, ST0);
    exp_span(20, 22, RUN0);
    wait_to(10);
    bus.pll_locked = 1'b1;
    wait_to(23);
  endtask

  task automatic loss(input int rb, input int len);
    int ds;
    int e_c;
    int ra;
    scen = "loss";
    c0 = cyc;
    ds = 2;
    e_c = ds + len + 2;
    ra = (rb == 3) ? 3 : rb + 1;
    exp_span(0, e_c - 1, v(1'b0, 1'b1, 1'b0, 1'b0, 2'(rb), 3'd3));
    exp_span(e_c, e_c, v(1'b1, 1'b0, 1'b1, 1'b0, 2'(ra), 3'd0));
    exp_span(e_c + 1, e_c + 3, v(1'b1, 1'b0, 1'b0, 1'b0, 2'(ra), 3'd0));
    exp_span(e_c + 4, e_c + 4, v(1'b0, 1'b0, 1'b0, 1'b0, 2'(ra), 3'd1));
    exp_span(e_c + 5, e_c + 11, v(1'b0, 1'b0, 1'b0, 1'b0, 2'(ra), 3'd2));
    exp_span(e_c + 12, e_c + 13, v(1'b0, 1'b1, 1'b0, 1'b0, 2'(ra), 3'd3));
    wait_to(ds);
    bus.pll_locked = 1'b0;
    wait_to(ds + len);
    bus.pll_locked = 1'b1;
    wait_to(e_c + 14);
  endtask

`ifdef PLL_SUP_LOSS_FILTER_EN
  task automatic glitch(input int len);
    scen = "filtered_glitch";
    c0 = cyc;
    exp_span(0, 10, RUN0);
    wait_to(2);
    bus.pll_locked = 1'b0;
    wait_to(2 + len);
    bus.pll_locked = 1'b1;
    wait_to(11);
  endtask
`endif

  // One timeout, then an unstable lock that must not count as a retry.
  task automatic unstable();
    scen = "unstable";
    exp_span(0, 3, R0);
    exp_span(4, 23, WL0);
    exp_span(24, 27, R0);
    exp_span(28, 32, WL0);
    exp_span(33, 37, ST0);
    exp_span(38, 38, WL0);
    exp_span(39, 45, ST0);
    exp_span(46, 48, RUN0);
    wait_to(30);
    bus.pll_locked = 1'b1;
    wait_to(35);
    bus.pll_locked = 1'b0;
    wait_to(36);
    bus.pll_locked = 1'b1;
    wait_to(49);
  endtask

  task automatic reset_in_stable();
    scen = "reset_in_stable";
    exp_span(0, 3, R0);
    exp_span(4, 12, WL0);
    exp_span(13, 14, ST0);
    wait_to(10);
    bus.pll_locked = 1'b1;
    wait_to(15);
  endtask

  task automatic timeout_fault();
    scen = "timeout_fault";
    exp_span(0, 3, R0);
    exp_span(4, 23, WL0);
    exp_span(24, 27, R0);
    exp_span(28, 47, WL0);
    exp_span(48, 60, FLT0);
    wait_to(50);
    bus.pll_locked = 1'b1;
    wait_to(61);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    @(posedge clk);
    #1;
    reset_now();
    bring_up_clean();
`ifdef PLL_SUP_LOSS_FILTER_EN
    glitch(1);
    glitch(3);
    len = 4;
`else
    len = 1;
`endif
    loss(0, len);
    loss(1, len);
    loss(2, len);
    loss(3, len);
    reset_now();
    unstable();
    reset_now();
    reset_in_stable();
    reset_now();
    bring_up_clean();
    reset_now();
    timeout_fault();
    reset_now();
    bring_up_clean();
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
